// File: rtl/mmc5_snd_ctrl.sv
// MMC5 expansion-audio control: frame sequencer strobes, channel enables,
// raw PCM register / PRG-read PCM capture with IRQ, and $5010/$5015 readback.
module mmc5_snd_ctrl #(
   parameter int unsigned FRAME_LEN = 29830,
   parameter int unsigned Q1        = 7457,
   parameter int unsigned Q2        = 14912,
   parameter int unsigned Q3        = 22370,
   parameter int unsigned Q4        = 29828
) (
   input  logic        m2,
   input  logic        rst,
   input  logic [7:0]  cpu_dat,
   input  logic [14:0] cpu_addr,
   input  logic        cpu_rw,
   input  logic        cpu_ce,
   input  logic        prg_rd,
   input  logic [1:0]  len_nz,
   output logic        e_clk,
   output logic        l_clk,
   output logic [1:0]  ch_en,
   output logic [7:0]  pcm,
   output logic        irq_n,
   output logic [7:0]  dout,
   output logic        dout_oe
);

   localparam int unsigned CTR_W     = $clog2(FRAME_LEN);
   localparam logic [14:0] ADDR_CTRL = 15'h5010;
   localparam logic [14:0] ADDR_RAW  = 15'h5011;
   localparam logic [14:0] ADDR_STAT = 15'h5015;

   logic [CTR_W-1:0] frame_ctr;
   logic [CTR_W-1:0] frame_nxt;
   logic             quarter;
   logic             half;
   logic             mode;
   logic             mode_nxt;
   logic             irq_en;
   logic             irq_en_nxt;
   logic             irq_pending;
   logic             pend_nxt;
   logic [1:0]       ch_en_nxt;
   logic [7:0]       pcm_nxt;
   logic             wr;
   logic             rd;
   logic             hit_ctrl;
   logic             hit_raw;
   logic             hit_stat;

   assign wr       = cpu_ce & ~cpu_rw;
   assign rd       = cpu_ce & cpu_rw;
   assign hit_ctrl = (cpu_addr == ADDR_CTRL);
   assign hit_raw  = (cpu_addr == ADDR_RAW);
   assign hit_stat = (cpu_addr == ADDR_STAT);

   // Next-state for the frame sequencer and the register file
   always_comb begin
      frame_nxt  = frame_ctr + CTR_W'(1);
      quarter    = 1'b0;
      half       = 1'b0;
      ch_en_nxt  = ch_en;
      mode_nxt   = mode;
      irq_en_nxt = irq_en;
      pend_nxt   = irq_pending;
      pcm_nxt    = pcm;

      if (frame_ctr == CTR_W'(FRAME_LEN - 1))
         frame_nxt = '0;
      if ((frame_ctr == CTR_W'(Q2)) || (frame_ctr == CTR_W'(Q4)))
         half = 1'b1;
      if (half || (frame_ctr == CTR_W'(Q1)) || (frame_ctr == CTR_W'(Q3)))
         quarter = 1'b1;

      if (wr && hit_stat)
         ch_en_nxt = cpu_dat[1:0];
      if (wr && hit_ctrl) begin
         mode_nxt   = cpu_dat[0];
         irq_en_nxt = cpu_dat[7];
      end
      if (!mode && wr && hit_raw && (cpu_dat != 8'h00))
         pcm_nxt = cpu_dat;

      // Status read acknowledges the IRQ, but a zero sample on the same edge re-arms it
      if (rd && hit_ctrl)
         pend_nxt = 1'b0;
      if (mode && prg_rd) begin
         if (cpu_dat != 8'h00)
            pcm_nxt = cpu_dat;
         else
            pend_nxt = 1'b1;
      end
   end

   always_ff @(negedge m2 or negedge rst) begin
      if (!rst) begin
         frame_ctr   <= '0;
         e_clk       <= 1'b0;
         l_clk       <= 1'b0;
         ch_en       <= 2'b00;
         mode        <= 1'b0;
         irq_en      <= 1'b0;
         irq_pending <= 1'b0;
         pcm         <= 8'h00;
         irq_n       <= 1'b1;
      end else begin
         frame_ctr   <= frame_nxt;
         e_clk       <= quarter;
         l_clk       <= half;
         ch_en       <= ch_en_nxt;
         mode        <= mode_nxt;
         irq_en      <= irq_en_nxt;
         irq_pending <= pend_nxt;
         pcm         <= pcm_nxt;
         irq_n       <= ~(irq_pending & irq_en);
      end
   end

   // Readback is combinational so the CPU sees it within the current read cycle
   always_comb begin
      dout    = 8'h00;
      dout_oe = 1'b0;
      if (rd && hit_ctrl) begin
         dout    = {irq_pending, 7'b0};
         dout_oe = 1'b1;
      end else if (rd && hit_stat) begin
         dout    = {6'b0, len_nz};
         dout_oe = 1'b1;
      end
   end

endmodule
